// File: rtl/enc_arb8_if.sv
// enc_arb8_if: request/grant bundle between the requesters and the enc_arb8 arbiter.
interface enc_arb8_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic [6:0] h0;
   logic [6:0] h7;
   modport master (output req, input gnt, gnt_idx, gnt_vld, h0, h7);
   modport slave (input req, output gnt, gnt_idx, gnt_vld, h0, h7);
endinterface

// File: rtl/enc_arb8.sv
// enc_arb8: 8-way arbiter with bounded grant hold and seven-segment status readout.
// Define ENC_ARB8_ROUND_ROBIN_EN for round-robin selection; fixed highest-index priority otherwise.
module enc_arb8 #(
   parameter int HOLD_CYCLES = 4
) (
   input logic       clk,
   input logic       rst,
   enc_arb8_if.slave bus
);
   typedef enum logic {IDLE, GRANT} state_t;
   localparam logic [6:0] BLANK = 7'b1111111;
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] idx_q, idx_d;
   logic       vld_q, vld_d;
   logic [6:0] h0_q, h0_d;
   logic [6:0] h7_q, h7_d;
   logic [2:0] win;
   function automatic logic [6:0] seg7(input logic [2:0] d);
      case (d)
         3'd0:    return 7'b1000000;
         3'd1:    return 7'b1111001;
         3'd2:    return 7'b0100100;
         3'd3:    return 7'b0110000;
         3'd4:    return 7'b0011001;
         3'd5:    return 7'b0010010;
         3'd6:    return 7'b0000010;
         default: return 7'b1111000;
      endcase
   endfunction
`ifdef ENC_ARB8_ROUND_ROBIN_EN
   logic [2:0] ptr_q, ptr_d;
   // Scan from ptr+8 down to ptr+1 so the last hit is the nearest bit above ptr.
   always_comb begin
      win = ptr_q;
      for (int i = 8; i >= 1; i--)
         if (bus.req[ptr_q + 3'(i)]) win = ptr_q + 3'(i);
   end
`else
   always_comb begin
      win = '0;
      for (int i = 0; i < 8; i++)
         if (bus.req[i]) win = 3'(i);
   end
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      h0_d    = h0_q;
      h7_d    = h7_q;
`ifdef ENC_ARB8_ROUND_ROBIN_EN
      ptr_d   = ptr_q;
`endif
      if (state_q == IDLE) begin
         if (|bus.req) begin
            state_d = GRANT;
            cnt_d   = 8'd1;
            gnt_d   = 8'b1 << win;
            idx_d   = win;
            vld_d   = 1'b1;
            h0_d    = seg7(win);
            h7_d    = seg7(3'd1);
`ifdef ENC_ARB8_ROUND_ROBIN_EN
            ptr_d   = win;
`endif
         end
      end else if (cnt_q == 8'(HOLD_CYCLES) || !bus.req[idx_q]) begin
         state_d = IDLE;
         cnt_d   = '0;
         gnt_d   = '0;
         vld_d   = 1'b0;
         h0_d    = BLANK;
         h7_d    = seg7(3'd0);
      end else begin
         cnt_d   = cnt_q + 8'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         h0_q    <= BLANK;
         h7_q    <= seg7(3'd0);
`ifdef ENC_ARB8_ROUND_ROBIN_EN
         ptr_q   <= 3'd7;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         h0_q    <= h0_d;
         h7_q    <= h7_d;
`ifdef ENC_ARB8_ROUND_ROBIN_EN
         ptr_q   <= ptr_d;
`endif
      end
   end
   assign bus.gnt     = gnt_q;
   assign bus.gnt_idx = idx_q;
   assign bus.gnt_vld = vld_q;
   assign bus.h0      = h0_q;
   assign bus.h7      = h7_q;
endmodule

// File: doc/enc_arb8.md
ENC_ARB8 -- requirements
Module: enc_arb8

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, maximum grant duration in cycles (legal range 1..255).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: req  input  8  request vector; bit i = requester i (switch inputs, level-sensitive).
REQ-005 Port: gnt  output  8  one-hot grant vector, registered.
REQ-006 Port: gnt_idx  output  3  binary index of granted requester, registered.
REQ-007 Port: gnt_vld  output  1  high while any grant is active, registered.
REQ-008 Port: h0  output  7  seven-segment code for gnt_idx; bit0 = seg a ... bit6 = seg g; active-low.
REQ-009 Port: h7  output  7  seven-segment code for gnt_vld (digit 1 or 0), same encoding.

Function
REQ-010 States: IDLE, GRANT; encoded in a 1-bit registered state.
REQ-011 IDLE: if req != 0 at edge N, select winner W, enter GRANT; gnt = one-hot(W), gnt_idx = W, gnt_vld = 1 visible after edge N (1-cycle latency).
REQ-012 IDLE with req == 0: remain IDLE; gnt = 0, gnt_idx holds last value, gnt_vld = 0.
REQ-013 GRANT: hold counter loads 1 on entry, increments each cycle in GRANT.
REQ-014 GRANT exit on edge where counter == HOLD_CYCLES or req[W] == 0 (early release), whichever first; next state IDLE, gnt = 0, gnt_vld = 0.
REQ-015 Simultaneous timeout and release: single exit, identical behaviour.
REQ-016 Changes to req bits other than W during GRANT: ignored; no preemption.
REQ-017 Mandatory one-cycle IDLE gap between consecutive grants, even with requests pending.
REQ-018 gnt SHALL never have more than one bit set; gnt_vld == (gnt != 0) at all times.
REQ-019 h0: digit of gnt_idx when gnt_vld = 1, blank (7'b1111111) when gnt_vld = 0.
REQ-020 h7: digit 1 when gnt_vld = 1, digit 0 otherwise.
REQ-021 Digit codes (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-022 h0/h7 registered, updated on the same edge as gnt (no extra latency).

Reset
REQ-023 rst high at edge: state = IDLE, gnt = 0, gnt_idx = 0, gnt_vld = 0, counter = 0, h0 = blank, h7 = digit 0, round-robin pointer = 7.
REQ-024 rst mid-GRANT: grant dropped on that edge; no residual grant after reset deasserts.
REQ-025 rst takes priority over all other events in the same cycle.

Configuration
REQ-026 Macro ENC_ARB8_ROUND_ROBIN_EN defined: winner = first set req bit searching upward from (ptr+1) mod 8 with wrap; ptr updated to W on each grant entry.
REQ-027 Macro undefined: fixed priority, winner = highest-index set req bit (matches 8-3 priority encoder); pointer logic absent.

Verification
REQ-028 Reset then req=8'h00 for 5 cycles -> gnt=0, gnt_vld=0, h0=7'b1111111, h7=7'b1000000.
REQ-029 req=8'h81 held, HOLD_CYCLES=4, macro undefined -> gnt=8'h80, gnt_idx=7, h0=7'b1111000 for 4 cycles, 1 idle cycle, regrant 8'h80.
REQ-030 req=8'h81 held, macro defined -> grant sequence idx 0, 7, 0, 7 each 4 cycles separated by 1 idle cycle.
REQ-031 req=8'h04 granted, drop req[2] at grant cycle 2 -> gnt=0 on next edge, gnt_vld=0, h0 blank.
REQ-032 rst asserted during grant cycle 3 of idx 5 -> all outputs at reset values next cycle; ptr=7 (macro defined: next req=8'hFF grants idx 0).
REQ-033 Random req for 10k cycles -> gnt one-hot or zero, gnt_vld==(gnt!=0), no grant longer than HOLD_CYCLES, gap >= 1 cycle between grants.
